// File: rtl/imm_extend_stage_if.sv
// Handshake bundle for the immediate-extension stage: an upstream request
// channel (imm/mode/tag) and a downstream result channel (data/tag/neg).
interface imm_extend_stage_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_neg;

  // Environment side: produces requests, consumes results.
  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_neg
  );

  // Stage side.
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_neg
  );
endinterface

// File: rtl/imm_extend_stage.sv
// Immediate-extension stage: extends an IN_W immediate to OUT_W by mode
// (sign / zero / upper / branch) and registers the result behind a
// main + skid register pair so in_ready comes straight from a flop.
module imm_extend_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  imm_extend_stage_if.slave bus
);

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_data;

  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic [TAG_W-1:0] main_tag_q,  main_tag_d;
  logic             main_v_q,    main_v_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;
  logic             skid_v_q,    skid_v_d;

  logic acc;
  logic pop;

  assign acc = bus.in_valid && !skid_v_q;
  assign pop = main_v_q && bus.out_ready;

  // Extension is purely combinational on the incoming immediate; only the
  // extended result is stored.
  always_comb begin
    sign_ext = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
    ext_data = sign_ext;
    case (bus.in_mode)
      MODE_SIGN:   ext_data = sign_ext;
      MODE_ZERO:   ext_data = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
      MODE_UPPER:  ext_data = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: ext_data = {sign_ext[OUT_W-3:0], 2'b00};
      default:     ext_data = sign_ext;
    endcase
  end

  // Main/skid next state. Skid is only filled when main is stalled, and is
  // always drained into main before any new item, which keeps order FIFO.
  always_comb begin
    main_data_d = main_data_q;
    main_tag_d  = main_tag_q;
    main_v_d    = main_v_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    skid_v_d    = skid_v_q;

    if (!main_v_q) begin
      if (acc) begin
        main_data_d = ext_data;
        main_tag_d  = bus.in_tag;
        main_v_d    = 1'b1;
      end
    end else if (pop) begin
      if (skid_v_q) begin
        main_data_d = skid_data_q;
        main_tag_d  = skid_tag_q;
        skid_v_d    = 1'b0;
      end else if (acc) begin
        main_data_d = ext_data;
        main_tag_d  = bus.in_tag;
      end else begin
        main_v_d    = 1'b0;
      end
    end else if (acc) begin
      skid_data_d = ext_data;
      skid_tag_d  = bus.in_tag;
      skid_v_d    = 1'b1;
    end
  end

  // State registers; reset clears flags and the visible output value.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_q <= '0;
      main_tag_q  <= '0;
      main_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_v_q    <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      main_tag_q  <= main_tag_d;
      main_v_q    <= main_v_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      skid_v_q    <= skid_v_d;
    end
  end

  assign bus.in_ready  = !skid_v_q;
  assign bus.out_valid = main_v_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_tag   = main_tag_q;
  assign bus.out_neg   = main_data_q[OUT_W-1];

endmodule
